vram_writer: RTL

- CPU-side write port for the video picture memories: palette (16 x 12b), tile definitions (16384 x 4b) and tile map (300 x 6b).
- Accepts 16-bit address/data writes over a valid/ready handshake and buffers them in a FIFO.
- Decodes each address to a memory region and issues one write strobe per cycle.
- When gating is enabled, commits only while the display is in vertical blanking, so the scan-out read path never sees a torn frame.

---
 rtl/vram_writer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vram_writer.sv
// CPU write port for the palette, tile-definition and tile-map memories.
// Writes are queued in a FIFO and committed one per cycle, optionally only during vblank.
module vram_writer #(
  parameter int FIFO_DEPTH  = 8,
  parameter bit GATE_VBLANK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        vblank,
  output logic        pal_we,
  output logic [3:0]  pal_addr,
  output logic [11:0] pal_data,
  output logic        td_we,
  output logic [13:0] td_addr,
  output logic [3:0]  td_data,
  output logic        tm_we,
  output logic [8:0]  tm_addr,
  output logic [5:0]  tm_data,
  output logic        err,
  output logic        busy,
  output logic [6:0]  fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [6:0]    count_reg, count_next;
  logic [1:0]    state_reg, state_next;
  logic          push, pop, can_commit, window_open;

  logic [15:0] head_addr, head_data, tm_offset;
  logic        is_td, is_tm, is_pal;

  assign wr_ready    = (count_reg != DEPTH_C);
  assign push        = wr_valid && wr_ready;
  assign window_open = vblank || !GATE_VBLANK;
  assign can_commit  = (count_reg != 7'd0) && window_open;
  // Pops are not held off by the FSM so an idle FIFO still meets the two-clock latency.
  assign pop         = can_commit;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {wr_addr, wr_data};
    end
  end

  assign head_addr = mem[rd_ptr_reg][31:16];
  assign head_data = mem[rd_ptr_reg][15:0];
  assign tm_offset = head_addr - 16'h4000;

  assign is_td  = (head_addr[15:14] == 2'b00);
  assign is_tm  = (head_addr >= 16'h4000) && (head_addr <= 16'h412B);
  assign is_pal = (head_addr[15:4] == 12'h420);

  logic unused_bits;
  assign unused_bits = ^{wr_data[15:12], head_data[15:12], tm_offset[15:9]};

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 7'd1;
      2'b01:   count_next = count_reg - 7'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != 7'd0) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (count_next == 7'd0) state_next = ST_IDLE;
        else if (can_commit)    state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_next == 7'd0) state_next = ST_IDLE;
        else if (!window_open)  state_next = ST_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= ST_IDLE;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      state_reg <= state_next;
    end
  end

  // Strobes last one cycle; address/data registers keep the last committed value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pal_we   <= 1'b0;
      pal_addr <= '0;
      pal_data <= '0;
      td_we    <= 1'b0;
      td_addr  <= '0;
      td_data  <= '0;
      tm_we    <= 1'b0;
      tm_addr  <= '0;
      tm_data  <= '0;
      err      <= 1'b0;
    end else begin
      pal_we <= 1'b0;
      td_we  <= 1'b0;
      tm_we  <= 1'b0;
      err    <= 1'b0;
      if (pop) begin
        if (is_td) begin
          td_we   <= 1'b1;
          td_addr <= head_addr[13:0];
          td_data <= head_data[3:0];
        end else if (is_tm) begin
          tm_we   <= 1'b1;
          tm_addr <= tm_offset[8:0];
          tm_data <= head_data[5:0];
        end else if (is_pal) begin
          pal_we   <= 1'b1;
          pal_addr <= head_addr[3:0];
          pal_data <= head_data[11:0];
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  assign busy       = (count_reg != 7'd0) || pal_we || td_we || tm_we;
  assign fifo_count = count_reg;

endmodule
